// File: rtl/crtc_bus_arbiter.sv
// Responder side of the CRTC text-DMA handshake: requests the Z80 bus on behalf
// of the CRTC, grants it once BUSAK arrives, and steers the RAM address.
module crtc_bus_arbiter #(
  parameter int HOLDOFF_CYCLES = 64,
  parameter int ACK_TIMEOUT    = 4095,
  parameter int CW             = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        crtc_busreq,
  output logic        crtc_busack,
  input  logic [16:0] crtc_adr,
  input  logic [15:0] cpu_adr,
  output logic        cpu_busrq_n,
  input  logic        cpu_busak_n,
  output logic [16:0] ram_adr,
  output logic        dma_active,
  output logic        ack_timeout,
  output logic [15:0] burst_len
);

  typedef enum logic [2:0] {IDLE, REQ, GRANT, RELEASE, HOLDOFF} state_t;

  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF_CYCLES);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [15:0]   acc, acc_nx, acc_inc;
  logic [15:0]   burst_nx;
  logic          timeout_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    acc_nx     = acc;
    burst_nx   = burst_len;
    timeout_nx = ack_timeout;
    cnt_inc    = cnt + CW'(1);
    acc_inc    = (acc == 16'hFFFF) ? acc : acc + 16'd1;
    case (state)
      IDLE: begin
        if (crtc_busreq) begin
          state_nx = REQ;
          cnt_nx   = '0;
        end
      end
      REQ: begin
        cnt_nx = cnt_inc;
        // A withdrawn request beats a simultaneous acknowledge.
        if (!crtc_busreq) begin
          state_nx = RELEASE;
        end else if (!cpu_busak_n) begin
          state_nx = GRANT;
          acc_nx   = '0;
        end else if (cnt_inc == ACK_LIM) begin
          state_nx   = RELEASE;
          timeout_nx = 1'b1;
        end
      end
      GRANT: begin
        // acc counts grant cycles after the first, so the exit value is acc+1.
        acc_nx = acc_inc;
        if (!crtc_busreq) begin
          state_nx = RELEASE;
          burst_nx = acc_inc;
        end
      end
      RELEASE: begin
        if (cpu_busak_n) begin
          state_nx = HOLDOFF;
          cnt_nx   = HOLD_LD;
        end
      end
      HOLDOFF: begin
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      burst_len   <= '0;
      ack_timeout <= 1'b0;
      cpu_busrq_n <= 1'b1;
      crtc_busack <= 1'b0;
      dma_active  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      acc         <= acc_nx;
      burst_len   <= burst_nx;
      ack_timeout <= timeout_nx;
      cpu_busrq_n <= !((state_nx == REQ) || (state_nx == GRANT));
      crtc_busack <= (state_nx == GRANT);
      dma_active  <= (state_nx == REQ) || (state_nx == GRANT) || (state_nx == RELEASE);
    end
  end

  assign ram_adr = (state == GRANT) ? crtc_adr : {1'b0, cpu_adr};

endmodule

// File: tb/tb_crtc_bus_arbiter.sv
// Directed bench for crtc_bus_arbiter; expected values are queued at stimulus
// time and popped when the corresponding DUT output is sampled.
module tb_crtc_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        crtc_busreq;
  logic        crtc_busack;
  logic [16:0] crtc_adr;
  logic [15:0] cpu_adr;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [16:0] ram_adr;
  logic        dma_active;
  logic        ack_timeout;
  logic [15:0] burst_len;

  crtc_bus_arbiter #(
    .HOLDOFF_CYCLES(64),
    .ACK_TIMEOUT   (100),
    .CW            (12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .crtc_busreq(crtc_busreq),
    .crtc_busack(crtc_busack),
    .crtc_adr   (crtc_adr),
    .cpu_adr    (cpu_adr),
    .cpu_busrq_n(cpu_busrq_n),
    .cpu_busak_n(cpu_busak_n),
    .ram_adr    (ram_adr),
    .dma_active (dma_active),
    .ack_timeout(ack_timeout),
    .burst_len  (burst_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL sb_empty: observed %h with no expected value queued", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int granted, stray_adr, hi, lo, busack_seen, early_to;

  initial begin
    reset       = 1'b1;
    crtc_busreq = 1'b0;
    cpu_busak_n = 1'b1;
    crtc_adr    = 17'h1ABCD;
    cpu_adr     = 16'h1234;
    tick(2);

    // Reset state
    push("rst_busrq_n", 32'd1);       check(32'(cpu_busrq_n));
    push("rst_busack", 32'd0);        check(32'(crtc_busack));
    push("rst_dma", 32'd0);           check(32'(dma_active));
    push("rst_timeout", 32'd0);       check(32'(ack_timeout));
    push("rst_burst_len", 32'd0);     check(32'(burst_len));
    push("rst_ram_adr", 32'h01234);   check(32'(ram_adr));
    reset = 1'b0;
    tick(5);

    // Basic grant: request in cycle k, BUSRQ low in k+1, BUSAK at k+3, grant k+4..k+243
    crtc_busreq = 1'b1;
    push("g_busrq_n_k1", 32'd0);
    push("g_busack_k1", 32'd0);
    push("g_ram_k1", 32'h01234);
    tick(1);
    check(32'(cpu_busrq_n));
    check(32'(crtc_busack));
    check(32'(ram_adr));
    tick(2);
    push("g_busack_k3", 32'd0);       check(32'(crtc_busack));
    cpu_busak_n = 1'b0;
    push("g_grant_cycles", 32'd240);
    push("g_stray_adr", 32'd0);
    granted   = 0;
    stray_adr = 0;
    for (int i = 0; i < 240; i++) begin
      tick(1);
      if (crtc_busack === 1'b1 && ram_adr === crtc_adr) granted++;
      else stray_adr++;
      crtc_adr = crtc_adr + 17'h00111;
      if (i == 239) crtc_busreq = 1'b0;
    end
    check(32'(granted));
    check(32'(stray_adr));
    tick(1);  // release cycle R
    push("g_burst_len", 32'd240);     check(32'(burst_len));
    push("g_busack_rel", 32'd0);      check(32'(crtc_busack));
    push("g_busrq_n_rel", 32'd1);     check(32'(cpu_busrq_n));
    push("g_dma_rel", 32'd1);         check(32'(dma_active));
    push("g_ram_rel", 32'h01234);     check(32'(ram_adr));

    // Holdoff: re-request at R+1, BUSAK high sampled at R+2 -> HOLDOFF R+2..R+66,
    // IDLE R+67, REQ R+68: BUSRQ high for cycles R..R+67 = 68 cycles
    tick(1);
    crtc_busreq = 1'b1;
    cpu_busak_n = 1'b1;
    hi = 2;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (cpu_busrq_n === 1'b1) hi++;
      else break;
    end
    push("h_busrq_n_high", 32'd68);   check(32'(hi));

    // Watchdog: no acknowledge, 100 REQ cycles then RELEASE with sticky flag
    lo          = 1;
    busack_seen = 0;
    early_to    = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (crtc_busack !== 1'b0) busack_seen++;
      if (cpu_busrq_n === 1'b0) begin
        lo++;
        if (ack_timeout !== 1'b0) early_to++;
      end else break;
    end
    push("w_req_cycles", 32'd100);    check(32'(lo));
    push("w_busack_seen", 32'd0);     check(32'(busack_seen));
    push("w_early_timeout", 32'd0);   check(32'(early_to));
    push("w_timeout", 32'd1);         check(32'(ack_timeout));
    push("w_busrq_n", 32'd1);         check(32'(cpu_busrq_n));
    crtc_busreq = 1'b0;
    tick(80);
    push("w_timeout_sticky", 32'd1);  check(32'(ack_timeout));
    push("w_dma_idle", 32'd0);        check(32'(dma_active));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    push("w_timeout_cleared", 32'd0); check(32'(ack_timeout));

    // Withdrawn request: 3-cycle pulse gives 3 REQ cycles, no grant, no timeout
    crtc_busreq = 1'b1;
    lo          = 0;
    busack_seen = 0;
    early_to    = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (cpu_busrq_n === 1'b0) lo++;
      if (crtc_busack !== 1'b0) busack_seen++;
      if (ack_timeout !== 1'b0) early_to++;
      if (i == 2) crtc_busreq = 1'b0;
    end
    push("wd_low_cycles", 32'd3);     check(32'(lo));
    push("wd_busack_seen", 32'd0);    check(32'(busack_seen));
    push("wd_timeout_seen", 32'd0);   check(32'(early_to));
    push("wd_busrq_n_end", 32'd1);    check(32'(cpu_busrq_n));
    tick(80);

    // Reset mid-burst
    cpu_adr     = 16'hBEEF;
    crtc_adr    = 17'h0F00D;
    crtc_busreq = 1'b1;
    cpu_busak_n = 1'b0;
    tick(2);
    push("r_busack_grant", 32'd1);    check(32'(crtc_busack));
    push("r_ram_grant", 32'h0F00D);   check(32'(ram_adr));
    reset = 1'b1;
    tick(1);
    push("r_busack", 32'd0);          check(32'(crtc_busack));
    push("r_busrq_n", 32'd1);         check(32'(cpu_busrq_n));
    push("r_ram_adr", 32'h0BEEF);     check(32'(ram_adr));
    push("r_dma", 32'd0);             check(32'(dma_active));
    reset       = 1'b0;
    crtc_busreq = 1'b0;
    cpu_busak_n = 1'b1;
    tick(3);

    // Saturation: 70000+ grant cycles, then RELEASE waits for BUSAK to rise
    crtc_busreq = 1'b1;
    cpu_busak_n = 1'b0;
    tick(2);
    push("s_busack", 32'd1);          check(32'(crtc_busack));
    tick(70000);
    crtc_busreq = 1'b0;
    tick(1);
    push("s_burst_len", 32'hFFFF);    check(32'(burst_len));
    push("s_busack_rel", 32'd0);      check(32'(crtc_busack));
    tick(5);
    push("s_dma_wait", 32'd1);        check(32'(dma_active));
    push("s_busrq_n_wait", 32'd1);    check(32'(cpu_busrq_n));
    cpu_busak_n = 1'b1;
    tick(1);
    push("s_dma_holdoff", 32'd0);     check(32'(dma_active));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
